// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding (common with uart_tx).
// The parity state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned BITWIDTH_DEF = 8;
  localparam int unsigned SB_TICK_DEF  = 16;
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned MID_TICK     = 7;
  localparam int unsigned TICK_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: tick/line inputs and the received byte with its flags.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEF
);
  logic                s_tick;
  logic                rx;
  logic [BITWIDTH-1:0] rx_dout;
  logic                rx_done_tick;
  logic                frame_err;
`ifdef UART_RX_PARITY_EN
  logic                parity_err;
`endif

  modport master (
    input  s_tick, rx,
    output rx_dout, rx_done_tick, frame_err
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport slave (
    output s_tick, rx,
    input  rx_dout, rx_done_tick, frame_err
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 (idle-high lines).
module uart_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, 1 start / BITWIDTH data / 1 stop.
// Optional even parity check when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BITWIDTH = BITWIDTH_DEF,
  parameter int unsigned SB_TICK  = SB_TICK_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master bus
);
  localparam int unsigned NW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [TICK_W-1:0] MID_S  = TICK_W'(MID_TICK);
  localparam logic [TICK_W-1:0] LAST_S = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_S = TICK_W'(SB_TICK - 1);
  localparam logic [NW-1:0]     LAST_N = NW'(BITWIDTH - 1);

  logic                rx_s, rx_q, fall_c;
  uart_state_e         state, state_nxt;
  logic [TICK_W-1:0]   s, s_nxt;
  logic [NW-1:0]       n, n_nxt;
  logic [BITWIDTH-1:0] b, b_nxt;
  logic [BITWIDTH-1:0] dout_nxt;
  logic                done_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                p_bad, p_bad_nxt, perr_nxt;
`endif

  uart_sync u_sync (.clk(clk), .reset_n(reset_n), .d(bus.rx), .q(rx_s));

  // Only a high-to-low transition starts a frame; a held-low line does not.
  assign fall_c = rx_q & ~rx_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      rx_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
      p_bad <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
      b     <= b_nxt;
      rx_q  <= rx_s;
`ifdef UART_RX_PARITY_EN
      p_bad <= p_bad_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    b_nxt     = b;
`ifdef UART_RX_PARITY_EN
    p_bad_nxt = p_bad;
`endif
    case (state)
      ST_IDLE: begin
        if (fall_c) begin
          state_nxt = ST_START;
          s_nxt     = '0;
        end
      end
      ST_START: begin
        if (bus.s_tick) begin
          if (s == MID_S) begin
            if (!rx_s) begin
              state_nxt = ST_DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bus.s_tick) begin
          if (s == LAST_S) begin
            s_nxt = '0;
            b_nxt = {rx_s, b[BITWIDTH-1:1]};
            if (n == LAST_N) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = ST_PARITY;
`else
              state_nxt = ST_STOP;
`endif
            end else begin
              n_nxt = n + 1'b1;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bus.s_tick) begin
          if (s == LAST_S) begin
            p_bad_nxt = (^b) ^ rx_s;
            s_nxt     = '0;
            state_nxt = ST_STOP;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (bus.s_tick) begin
          if (s == STOP_S) begin
            state_nxt = ST_IDLE;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: all results update together mid stop bit
  always_comb begin
    done_nxt = 1'b0;
    dout_nxt = bus.rx_dout;
    ferr_nxt = bus.frame_err;
`ifdef UART_RX_PARITY_EN
    perr_nxt = bus.parity_err;
`endif
    if (state == ST_STOP && bus.s_tick && s == STOP_S) begin
      done_nxt = 1'b1;
      dout_nxt = b;
      ferr_nxt = ~rx_s;
`ifdef UART_RX_PARITY_EN
      perr_nxt = p_bad;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rx_dout      <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err   <= 1'b0;
`endif
    end else begin
      bus.rx_dout      <= dout_nxt;
      bus.rx_done_tick <= done_nxt;
      bus.frame_err    <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      bus.parity_err   <= perr_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, glitch, framing error, break,
// back-to-back frames and mid-frame reset; parity cases with UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned BW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = 168;
`else
  localparam int unsigned LAT = 152;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        ferr;
    logic        perr;
    int unsigned mark;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned tdiv = 0;
  int unsigned tcount = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_done = 1'b0;
  exp_t        q[$];
  exp_t        e;

  uart_rx_if #(.BITWIDTH(BW)) bus ();

  uart_rx #(.BITWIDTH(BW), .SB_TICK(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // s_tick every 4 clocks; tcount counts ticks seen by the DUT
  always @(posedge clk) tdiv <= (tdiv == 3) ? 0 : tdiv + 1;
  assign bus.s_tick = (tdiv == 3);
  always @(posedge clk) if (bus.s_tick) tcount <= tcount + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_done) check("done_width", 32'(bus.rx_done_tick), 32'd0);
      if (bus.rx_done_tick) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got rx_dout 0x%0h, expected no frame", bus.rx_dout);
        end else begin
          e = q.pop_front();
          check("rx_dout", 32'(bus.rx_dout), 32'(e.data));
          check("frame_err", 32'(bus.frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
          check("parity_err", 32'(bus.parity_err), 32'(e.perr));
`endif
          check("latency", tcount - e.mark, LAT);
        end
      end
    end
    prev_done = bus.rx_done_tick;
  end

  task automatic wait_ticks(input int unsigned nt);
    int unsigned t0;
    t0 = tcount;
    wait (tcount >= t0 + nt);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t x;
    x.data = d;
    x.ferr = ferr;
    x.perr = perr;
    x.mark = tcount;
    q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par_v;
    wait_ticks(16);
`else
    if (par_v !== 1'bx) bus.rx = bus.rx;
`endif
    bus.rx = stop_v;
    wait_ticks(16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int to;
    bus.rx = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_dout", 32'(bus.rx_dout), 32'd0);
    check("reset_done", 32'(bus.rx_done_tick), 32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_err", 32'(bus.parity_err), 32'd0);
`endif
    reset_n = 1'b1;
    wait_ticks(20);

    // Clean 0xA5 (even count of ones -> parity bit 0)
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_ticks(16);

    // 4-tick glitch must be rejected
    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(32);
    check("glitch_hold_dout", 32'(bus.rx_dout), 32'hA5);

    // 0x3C with low stop bit, then line held low (break)
    push_exp(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(48);
    check("break_hold_dout", 32'(bus.rx_dout), 32'h3C);
    check("break_hold_ferr", 32'(bus.frame_err), 32'd1);
    bus.rx = 1'b1;
    wait_ticks(16);

    // Frame after break recovers cleanly
    push_exp(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);

    // Back-to-back 0x00 then 0xFF with no idle gap
    push_exp(8'h00, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_ticks(16);

    // Abort 0xC3 during data bit 4 with reset
    bus.rx = 1'b0;
    wait_ticks(16);
    bus.rx = 1'b1; wait_ticks(16);
    bus.rx = 1'b1; wait_ticks(16);
    bus.rx = 1'b0; wait_ticks(16);
    bus.rx = 1'b0; wait_ticks(16);
    bus.rx = 1'b0; wait_ticks(8);
    reset_n = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_dout", 32'(bus.rx_dout), 32'd0);
    check("midreset_done", 32'(bus.rx_done_tick), 32'd0);
    reset_n = 1'b1;
    wait_ticks(32);
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_ticks(16);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1
    push_exp(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    push_exp(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_ticks(16);
`endif

    to = 0;
    while (q.size() != 0 && to < 2000) begin
      @(posedge clk);
      to++;
    end
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
